// File: rtl/abr_params_pkg.sv
// Shared memory-interface parameters for the ML-DSA accelerator.
package abr_params_pkg;
    localparam int ABR_MEM_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } mem_rw_mode_e;
endpackage

// File: rtl/sigencode_z_defines_pkg.sv
// Types and constants shared by the sigencode_z controller and its datapath.
package sigencode_z_defines_pkg;
    import abr_params_pkg::*;

    localparam int API_ADDR_WIDTH = ABR_MEM_ADDR_WIDTH;
    localparam int MLDSA_L        = 7;
    localparam int WORDS_PER_POLY = 64;
    localparam int MEM_RD_LATENCY = 1;
    localparam int ENC_LATENCY    = 1;
    localparam int POLY_CNT_W     = $clog2(MLDSA_L);
    localparam int WORD_CNT_W     = $clog2(WORDS_PER_POLY);

    typedef struct packed {
        mem_rw_mode_e              rd_wr_en;
        logic [API_ADDR_WIDTH-1:0] addr;
    } sig_mem_if_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } sigencode_z_ctrl_state_e;

    // Word offset of (poly, word) inside the z block, at address width.
    function automatic logic [API_ADDR_WIDTH-1:0] poly_word_offset(
        input logic [POLY_CNT_W-1:0] poly,
        input logic [WORD_CNT_W-1:0] word
    );
        return API_ADDR_WIDTH'(poly) * API_ADDR_WIDTH'(WORDS_PER_POLY) + API_ADDR_WIDTH'(word);
    endfunction
endpackage

// File: rtl/abr_delay_line.sv
// Fixed-depth shift register carrying a valid flag plus payload, with sync clear.
module abr_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             pending
);
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else if (clear) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // Entries still travelling behind the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) pending = pending | vld_q[i];
    end
endmodule

// File: rtl/sigencode_z_ctrl.sv
// Streams all z polynomials from working memory through the encoder into signature memory.
// state | meaning
// IDLE  | waiting for sigencode_z_enable
// READ  | one read request per cycle, 448 back-to-back
// FLUSH | reads finished, draining encoder/write pipeline
// DONE  | one-cycle done pulse
module sigencode_z_ctrl
    import abr_params_pkg::*;
    import sigencode_z_defines_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      zeroize,
    input  logic                      sigencode_z_enable,
    input  logic [API_ADDR_WIDTH-1:0] src_base_addr,
    input  logic [API_ADDR_WIDTH-1:0] dest_base_addr,
    output sig_mem_if_t               mem_rd_req,
    output sig_mem_if_t               sig_mem_wr_req,
    output logic                      enc_valid,
    output logic                      busy,
    output logic                      sigencode_z_done
);
    sigencode_z_ctrl_state_e   state_q, state_d;
    logic [POLY_CNT_W-1:0]     poly_cnt, poly_cnt_d;
    logic [WORD_CNT_W-1:0]     word_cnt, word_cnt_d;
    logic [API_ADDR_WIDTH-1:0] src_base_q, src_base_d;
    logic [API_ADDR_WIDTH-1:0] dest_base_q, dest_base_d;
    logic [API_ADDR_WIDTH-1:0] rd_offset_q, rd_offset_d;
    logic                      rd_issue_d, rd_valid;
    logic                      last_word;
    logic [API_ADDR_WIDTH-1:0] enc_offset, wr_offset;
    logic                      enc_pending, wr_valid, wr_pending;

    assign last_word = (poly_cnt == POLY_CNT_W'(MLDSA_L-1)) &&
                       (word_cnt == WORD_CNT_W'(WORDS_PER_POLY-1));
    assign rd_valid  = (mem_rd_req.rd_wr_en == RW_READ);

    // Counters always name the word whose read request is being registered.
    always_comb begin
        state_d     = state_q;
        poly_cnt_d  = poly_cnt;
        word_cnt_d  = word_cnt;
        src_base_d  = src_base_q;
        dest_base_d = dest_base_q;
        rd_issue_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sigencode_z_enable) begin
                    state_d     = READ;
                    src_base_d  = src_base_addr;
                    dest_base_d = dest_base_addr;
                    poly_cnt_d  = '0;
                    word_cnt_d  = '0;
                    rd_issue_d  = 1'b1;
                end
            end
            READ: begin
                if (last_word) begin
                    state_d = FLUSH;
                end else begin
                    rd_issue_d = 1'b1;
                    if (word_cnt == WORD_CNT_W'(WORDS_PER_POLY-1)) begin
                        word_cnt_d = '0;
                        poly_cnt_d = poly_cnt + 1'b1;
                    end else begin
                        word_cnt_d = word_cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!rd_valid && !enc_valid && !enc_pending && !wr_pending) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
        rd_offset_d = poly_word_offset(poly_cnt_d, word_cnt_d);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            poly_cnt    <= '0;
            word_cnt    <= '0;
            src_base_q  <= '0;
            dest_base_q <= '0;
            rd_offset_q <= '0;
            mem_rd_req  <= '0;
        end else if (zeroize) begin
            state_q     <= IDLE;
            poly_cnt    <= '0;
            word_cnt    <= '0;
            src_base_q  <= '0;
            dest_base_q <= '0;
            rd_offset_q <= '0;
            mem_rd_req  <= '0;
        end else begin
            state_q     <= state_d;
            poly_cnt    <= poly_cnt_d;
            word_cnt    <= word_cnt_d;
            src_base_q  <= src_base_d;
            dest_base_q <= dest_base_d;
            rd_offset_q <= rd_issue_d ? rd_offset_d : '0;
            mem_rd_req.rd_wr_en <= rd_issue_d ? RW_READ : RW_IDLE;
            mem_rd_req.addr     <= rd_issue_d ? src_base_d + rd_offset_d : '0;
        end
    end

    // Read-side delay gives enc_valid; the encoder stage then delays the offset to the write.
    abr_delay_line #(.WIDTH(API_ADDR_WIDTH), .DEPTH(MEM_RD_LATENCY)) u_enc_dly (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (zeroize),
        .in_valid  (rd_valid),
        .in_data   (rd_offset_q),
        .out_valid (enc_valid),
        .out_data  (enc_offset),
        .pending   (enc_pending)
    );

    abr_delay_line #(.WIDTH(API_ADDR_WIDTH), .DEPTH(ENC_LATENCY)) u_wr_dly (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (zeroize),
        .in_valid  (enc_valid),
        .in_data   (enc_offset),
        .out_valid (wr_valid),
        .out_data  (wr_offset),
        .pending   (wr_pending)
    );

    always_comb begin
        sig_mem_wr_req = '0;
        if (wr_valid) begin
            sig_mem_wr_req.rd_wr_en = RW_WRITE;
            sig_mem_wr_req.addr     = dest_base_q + wr_offset;
        end
    end

    assign busy             = (state_q == READ) || (state_q == FLUSH);
    assign sigencode_z_done = (state_q == DONE);
endmodule

// File: tb/tb_sigencode_z_ctrl.sv
// Randomized self-checking bench for sigencode_z_ctrl against a cycle-offset reference model.
module tb_sigencode_z_ctrl;
    import abr_params_pkg::*;
    import sigencode_z_defines_pkg::*;

    localparam int AW  = API_ADDR_WIDTH;
    localparam int NRD = MLDSA_L * WORDS_PER_POLY;
    localparam int LAT = MEM_RD_LATENCY + ENC_LATENCY;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          zeroize = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    sig_mem_if_t   rd_req, wr_req;
    logic          enc_valid, busy, done;

    always #5 clk = ~clk;

    sigencode_z_ctrl dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .zeroize            (zeroize),
        .sigencode_z_enable (en),
        .src_base_addr      (src),
        .dest_base_addr     (dst),
        .mem_rd_req         (rd_req),
        .sig_mem_wr_req     (wr_req),
        .enc_valid          (enc_valid),
        .busy               (busy),
        .sigencode_z_done   (done)
    );

    int total = 0;
    int bad   = 0;
    bit act   = 1'b0;
    int c     = 0;
    int s_q   = 0;
    int d_q   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // c counts cycles after the start sample: cycle 1 carries the first read.
    task automatic check_outputs(input string where);
        int rd_e, wr_e, ev, bz, dn;
        rd_e = 0; wr_e = 0; ev = 0; bz = 0; dn = 0;
        if (act) begin
            if (c >= 1 && c <= NRD)
                rd_e = (int'(RW_READ) << AW) | ((s_q + c - 1) % (1 << AW));
            if (c >= 1 + MEM_RD_LATENCY && c <= NRD + MEM_RD_LATENCY) ev = 1;
            if (c >= 1 + LAT && c <= NRD + LAT)
                wr_e = (int'(RW_WRITE) << AW) | ((d_q + c - 1 - LAT) % (1 << AW));
            bz = (c >= 1 && c <= NRD + LAT) ? 1 : 0;
            dn = (c == NRD + LAT + 1) ? 1 : 0;
        end
        chk({where, "/rd"},   32'(rd_req),    32'(rd_e));
        chk({where, "/wr"},   32'(wr_req),    32'(wr_e));
        chk({where, "/enc"},  32'(enc_valid), 32'(ev));
        chk({where, "/busy"}, 32'(busy),      32'(bz));
        chk({where, "/done"}, 32'(done),      32'(dn));
    endtask

    task automatic cyc(input logic e, input logic zz);
        en = e;
        zeroize = zz;
        @(posedge clk);
        if (zz) act = 1'b0;
        else if (act) begin
            c++;
            if (c > NRD + LAT + 1) act = 1'b0;
        end else if (e) begin
            act = 1'b1;
            c = 1;
            s_q = int'(src);
            d_q = int'(dst);
        end
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic async_reset();
        #2 rst_b = 1'b0;
        act = 1'b0;
        #1 check_outputs("arst");
        en = 1'b0;
        zeroize = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs("arst_hold");
        rst_b = 1'b1;
    endtask

    task automatic run_op(input int s, input int d, input int en_at, input int zz_at,
                          input int rst_at, input bit stray);
        logic e;
        src = AW'(s);
        dst = AW'(d);
        cyc(1'b1, 1'b0);
        src = AW'($urandom);
        dst = AW'($urandom);
        for (int i = 1; i < NRD + LAT + 8; i++) begin
            e = act && ((i == en_at) || (stray && ($urandom_range(0, 7) == 0)));
            cyc(e, (i == zz_at) ? 1'b1 : 1'b0);
            if (i == rst_at) begin
                async_reset();
                break;
            end
            if (!act) break;
        end
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        check_outputs("reset");
        rst_b = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);

        run_op('h100, 'h800, -1, -1, -1, 1'b0);
        run_op((1 << AW) - 4, (1 << AW) - 2, -1, -1, -1, 1'b0);
        run_op(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, (1 << AW) - 1)),
               100, -1, -1, 1'b0);
        run_op(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, (1 << AW) - 1)),
               -1, 200, -1, 1'b0);
        run_op(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, (1 << AW) - 1)),
               -1, -1, NRD, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, (1 << AW) - 1)),
                   -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NRD + LAT)) : -1,
                   -1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sigencode_z_ctrl.md
Name: sigencode_z_ctrl

Overview:
- Sequences the ML-DSA sigencode_z datapath. On one start pulse it streams all MLDSA_L z polynomials out of working memory and writes the encoded words into signature memory.
- Issues one read request per cycle and asserts the datapath enable aligned with the read data.
- Issues each matching write request after a fixed pipeline delay, then pulses done.
- Sits between the top-level ML-DSA sequencer and the sigencode_z encode datapath / memory muxes.

Parameters:
- API_ADDR_WIDTH, ABR_MEM_ADDR_WIDTH (shared package): memory address width.
- MLDSA_L, 7 (shared package): number of z polynomials.
- WORDS_PER_POLY, 64: memory words per polynomial (256 coefficients, 4 per word).
- MEM_RD_LATENCY, 1: cycles from read request to read data valid.
- ENC_LATENCY, 1: cycles from encoder input valid to encoded word valid.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state, priority over everything except rst_b
- sigencode_z_enable  in  1  start pulse, sampled in IDLE only
- src_base_addr  in  API_ADDR_WIDTH  z polynomial base in working memory, captured at start
- dest_base_addr  in  API_ADDR_WIDTH  signature memory base, captured at start
- mem_rd_req  out  $bits(sig_mem_if_t)  read request {rd_wr_en, addr}
- sig_mem_wr_req  out  $bits(sig_mem_if_t)  write request {rd_wr_en, addr}
- enc_valid  out  1  read data on the memory return bus is valid; encoder must consume it
- busy  out  1  high from the cycle after start until the done pulse
- sigencode_z_done  out  1  single-cycle completion pulse

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_b).
- Reset and zeroize values: every output is 0, and the rd_wr_en fields are RW_IDLE. FSM goes to IDLE; all counters, captured bases and delay lines clear.
- FSM states are IDLE, READ, FLUSH, DONE.
- IDLE:
  - On sigencode_z_enable, capture both bases, clear poly_cnt (0..MLDSA_L-1) and word_cnt (0..WORDS_PER_POLY-1), and go to READ.
  - sigencode_z_enable is ignored in every other state.
- READ: each cycle, mem_rd_req = {RW_READ, src_base + poly_cnt*WORDS_PER_POLY + word_cnt}, registered output.
  - word_cnt increments and wraps to 0 at WORDS_PER_POLY-1, which also increments poly_cnt.
  - On the last word (poly_cnt = MLDSA_L-1, word_cnt = WORDS_PER_POLY-1), go to FLUSH.
- Total reads: MLDSA_L*WORDS_PER_POLY = 448. Reads are back-to-back with no gaps.
- Address arithmetic is unsigned and modulo 2^API_ADDR_WIDTH; wrap-around is silent. The offset is formed at API_ADDR_WIDTH bits.
- enc_valid asserts MEM_RD_LATENCY cycles after each read request; it is a shift-register delay of the read-issue flag.
- Write address delay line: the offset (poly_cnt*WORDS_PER_POLY + word_cnt) is delayed by MEM_RD_LATENCY+ENC_LATENCY.
  - sig_mem_wr_req = {RW_WRITE, dest_base + delayed offset} when the delayed valid is set, else {RW_IDLE, 0}.
  - The first write issues MEM_RD_LATENCY+ENC_LATENCY cycles after the first read.
- FLUSH: mem_rd_req = {RW_IDLE, 0}. Wait until the delay line is empty, i.e. the last write has issued, then go to DONE.
- DONE: sigencode_z_done = 1 for one cycle, busy drops in the same cycle, return to IDLE.
- Latency: start sampled at cycle 0 → first read at cycle 1 → last read at cycle 448 → last write at cycle 448+MEM_RD_LATENCY+ENC_LATENCY → done the next cycle.
- Read and write requests may be active in the same cycle; they target separate memories, so there is no conflict.
- Zeroize or rst_b mid-operation:
  - Aborts immediately, with no further requests and no done pulse.
  - In-flight delay-line entries are discarded.

Decomposition:
- Shared package (sigencode_z_defines_pkg):
  - Existing items: sig_mem_if_t, API_ADDR_WIDTH, MLDSA_L.
  - Add: WORDS_PER_POLY, and the state enum sigencode_z_ctrl_state_e {IDLE, READ, FLUSH, DONE}.
- mem_rw_mode_e comes from abr_params_pkg.
- One sub-module: abr_delay_line (parameterised width and depth, valid plus payload, synchronous clear input driven by zeroize). It is used for both the enc_valid delay and the write-address delay.

Test Plan:
- src=0x100, dst=0x800, pulse enable → 448 consecutive reads at 0x100..0x2BF from cycle 1, enc_valid at cycles 2..449, writes at 0x800..0x9BF at cycles 3..450, done pulse at cycle 451, busy high cycles 1..450.
- Check the polynomial boundary: the read after word_cnt=63 of poly 0 is addr 0x140 (poly 1, word 0), with no gap cycle.
- src=2^API_ADDR_WIDTH-4 → the 5th read address wraps to 0x0, with no error or stall.
- Pulse enable again during READ at cycle 100 → ignored: exactly 448 reads and one done pulse.
- Assert zeroize at cycle 200 → from the next cycle all requests are RW_IDLE, busy=0, no done. A new enable then restarts from word 0 with new bases.
- Drop rst_b asynchronously mid-FLUSH → outputs clear immediately without a clock edge, and no stray write appears after reset release.
